axi_mem_slave: RTL

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_slave.sv
// AXI slave backed by a word-addressed memory with byte-lane writes.
// The write path (AW/W/B) and read path (AR/R) run as two independent FSMs
// that share only the storage array; a read load and a write to the same
// word on the same edge returns the pre-write contents.
module axi_mem_slave #(
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        a_clk,
   input  logic        a_reset,
   // write address channel
   input  logic [3:0]  aw_id,
   input  logic [31:0] aw_addr,
   input  logic [3:0]  aw_len,
   input  logic [2:0]  aw_size,
   input  logic [1:0]  aw_burst,
   input  logic        aw_valid,
   output logic        aw_ready,
   // write data channel
   input  logic [3:0]  w_id,
   input  logic [31:0] w_data,
   input  logic [3:0]  w_strb,
   input  logic        w_last,
   input  logic        w_valid,
   output logic        w_ready,
   // write response channel
   output logic [3:0]  b_id,
   output logic [1:0]  b_resp,
   output logic        b_valid,
   input  logic        b_ready,
   // read address channel
   input  logic [3:0]  ar_id,
   input  logic [31:0] ar_addr,
   input  logic [3:0]  ar_len,
   input  logic [2:0]  ar_size,
   input  logic [1:0]  ar_burst,
   input  logic        ar_valid,
   output logic        ar_ready,
   // read data channel
   output logic [3:0]  r_id,
   output logic [31:0] r_data,
   output logic [1:0]  r_resp,
   output logic        r_last,
   output logic        r_valid,
   input  logic        r_ready
);

   localparam int         IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   logic [31:0] mem [MEM_WORDS];

   // WID is not used for routing: write data is always taken in order.
   logic unused_w_id;
   assign unused_w_id = ^w_id;

   // True when a burst cannot be served: wrong size, WRAP/reserved burst,
   // misaligned start, or any beat address outside the mapped window.
   // Computed in 34 bits so the end-of-burst sum cannot wrap.
   function automatic logic txn_bad(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
      logic [33:0] first_a, last_a, lo, hi;
      first_a = {2'b00, addr};
      last_a  = (burst == BURST_INCR) ? first_a + {28'd0, len, 2'b00} : first_a;
      lo      = {2'b00, BASE_ADDR};
      hi      = lo + (34'(MEM_WORDS) << 2);
      return (size != 3'b010) || burst[1] || (addr[1:0] != 2'b00) ||
             (first_a < lo) || (last_a >= hi);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
      return (burst == BURST_INCR) ? addr + 32'd4 : addr;
   endfunction

   // ---------------- write path ----------------
   w_state_t         w_state_q, w_state_d;
   logic [31:0]      w_addr_q;
   logic [3:0]       w_len_q, w_cnt_q;
   logic [1:0]       w_burst_q;
   logic             w_aerr_q, w_lerr_q;
   logic [31:0]      cur_addr;
   logic [3:0]       cur_len, cur_cnt;
   logic [1:0]       cur_burst;
   logic             cur_bad, aw_take, w_beat, w_beat_last, wr_en;
   logic [IDX_W-1:0] wr_idx;

   // Write FSM next state, handshake outputs and the current beat's target.
   always_comb begin
      w_state_d = w_state_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      b_resp    = RESP_OKAY;
      cur_addr  = w_addr_q;
      cur_len   = w_len_q;
      cur_cnt   = w_cnt_q;
      cur_burst = w_burst_q;
      cur_bad   = w_aerr_q;
      aw_take   = 1'b0;
      w_beat    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_ready  = 1'b1;
            w_ready   = 1'b1;
            cur_addr  = aw_addr;
            cur_len   = aw_len;
            cur_cnt   = 4'd0;
            cur_burst = aw_burst;
            cur_bad   = txn_bad(aw_addr, aw_len, aw_size, aw_burst);
            aw_take   = aw_valid;
            // a W beat alone in idle is ignored; it only counts alongside AW
            w_beat    = aw_valid & w_valid;
            if (aw_valid)
               w_state_d = (w_valid && aw_len == 4'd0) ? W_RESP : W_DATA;
         end
         W_DATA: begin
            w_ready = 1'b1;
            w_beat  = w_valid;
            if (w_valid && w_cnt_q == w_len_q)
               w_state_d = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            b_resp  = (w_aerr_q | w_lerr_q) ? RESP_SLVERR : RESP_OKAY;
            if (b_ready)
               w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      w_beat_last = (cur_cnt == cur_len);
      wr_en       = w_beat & ~cur_bad;
      wr_idx      = word_idx(cur_addr);
   end

   // Write FSM state and response bookkeeping.
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         w_state_q <= W_IDLE;
         b_id      <= 4'd0;
         w_aerr_q  <= 1'b0;
         w_lerr_q  <= 1'b0;
         w_cnt_q   <= 4'd0;
      end else begin
         w_state_q <= w_state_d;
         if (aw_take) begin
            b_id     <= aw_id;
            w_aerr_q <= cur_bad;
            w_lerr_q <= w_beat & (w_last != w_beat_last);
            w_cnt_q  <= w_beat ? 4'd1 : 4'd0;
         end else if (w_beat) begin
            w_lerr_q <= w_lerr_q | (w_last != w_beat_last);
            w_cnt_q  <= 4'(w_cnt_q + 4'd1);
         end
      end
   end

   // Latched burst shape and running beat address.
   always_ff @(posedge a_clk) begin
      if (aw_take) begin
         w_len_q   <= aw_len;
         w_burst_q <= aw_burst;
      end
      if (aw_take | w_beat)
         w_addr_q <= w_beat ? next_addr(cur_addr, cur_burst) : cur_addr;
   end

   // Byte-lane memory write; storage is never reset.
   always_ff @(posedge a_clk) begin
      for (int k = 0; k < 4; k++)
         if (wr_en && w_strb[k])
            mem[wr_idx][8*k +: 8] <= w_data[8*k +: 8];
   end

   // ---------------- read path ----------------
   r_state_t    r_state_q, r_state_d;
   logic [31:0] r_addr_q, rd_addr;
   logic [3:0]  r_len_q, r_cnt_q;
   logic [1:0]  r_burst_q;
   logic        r_err_q, rd_bad, rd_load, ar_take, r_hs, r_step;

   // Read FSM next state and the word to load into the R data register.
   always_comb begin
      r_state_d = r_state_q;
      rd_addr   = r_addr_q;
      rd_bad    = r_err_q;
      rd_load   = 1'b0;
      r_valid   = (r_state_q == R_DATA);
      r_hs      = r_valid & r_ready;
      // accepting AR on the final R handshake removes the idle bubble
      ar_ready  = (r_state_q == R_IDLE) | (r_hs & r_last);
      ar_take   = ar_valid & ar_ready;
      r_step    = r_hs & ~r_last;
      if (ar_take) begin
         rd_addr   = ar_addr;
         rd_bad    = txn_bad(ar_addr, ar_len, ar_size, ar_burst);
         rd_load   = 1'b1;
         r_state_d = R_DATA;
      end else if (r_step) begin
         rd_addr = next_addr(r_addr_q, r_burst_q);
         rd_load = 1'b1;
      end else if (r_hs) begin
         r_state_d = R_IDLE;
      end
   end

   // Read FSM state and the registered R channel payload.
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         r_state_q <= R_IDLE;
         r_id      <= 4'd0;
         r_resp    <= RESP_OKAY;
         r_last    <= 1'b0;
         r_data    <= 32'd0;
         r_err_q   <= 1'b0;
         r_cnt_q   <= 4'd0;
      end else begin
         r_state_q <= r_state_d;
         if (ar_take) begin
            r_id    <= ar_id;
            r_err_q <= rd_bad;
            r_resp  <= rd_bad ? RESP_SLVERR : RESP_OKAY;
            r_last  <= (ar_len == 4'd0);
            r_cnt_q <= 4'd0;
         end else if (r_step) begin
            r_cnt_q <= 4'(r_cnt_q + 4'd1);
            r_last  <= (4'(r_cnt_q + 4'd1) == r_len_q);
         end else if (r_hs) begin
            r_last <= 1'b0;
         end
         if (rd_load)
            r_data <= rd_bad ? 32'd0 : mem[word_idx(rd_addr)];
      end
   end

   // Latched read burst shape and running beat address.
   always_ff @(posedge a_clk) begin
      if (ar_take) begin
         r_len_q   <= ar_len;
         r_burst_q <= ar_burst;
         r_addr_q  <= ar_addr;
      end else if (r_step) begin
         r_addr_q <= rd_addr;
      end
   end

endmodule
